// File: rtl/shift_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : shift_seq                                                     |
// | Description : Multi-cycle barrel-shift sequencer (LSL/LSR/ASR/ROR) with    |
// |               ARM-style carry. Define SHIFT_SEQ_FAST_EN for 4-bit steps.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module shift_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic [1:0]  shift_type,
  input  logic [31:0] val_rm,
  input  logic [7:0]  amount,
  input  logic        carry_in,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        carry_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] c_lsl = 2'b00;
  localparam logic [1:0] c_lsr = 2'b01;
  localparam logic [1:0] c_asr = 2'b10;

  state_t      r_state;
  logic [31:0] r_val;
  logic [5:0]  r_cnt;
  logic [1:0]  r_type;

  logic [5:0]  w_n;
  logic        w_zero_c;
  logic        w_step4;
  logic [31:0] w_nv;
  logic        w_nc;
  logic [5:0]  w_ncnt;

  // Step count at issue; ROR only uses the low five bits of the amount.
  always_comb begin
    w_n = 6'd0;
    case (shift_type)
      c_asr:   w_n = (amount > 8'd32) ? 6'd32 : amount[5:0];
      2'b11:   w_n = {1'b0, amount[4:0]};
      default: w_n = (amount > 8'd33) ? 6'd33 : amount[5:0];
    endcase
  end

  // With no steps, carry is the incoming flag unless ROR by a multiple of 32.
  assign w_zero_c = (amount == 8'd0) ? carry_in : val_rm[31];

  always_comb begin
    w_step4 = 1'b0;
`ifdef SHIFT_SEQ_FAST_EN
    w_step4 = (r_cnt >= 6'd4);
`endif
  end

  always_comb begin
    w_nv   = r_val;
    w_nc   = 1'b0;
    w_ncnt = r_cnt - 6'd1;
    if (w_step4) begin
      w_ncnt = r_cnt - 6'd4;
      case (r_type)
        c_lsl:   begin w_nv = {r_val[27:0], 4'b0000};         w_nc = r_val[28]; end
        c_lsr:   begin w_nv = {4'b0000, r_val[31:4]};         w_nc = r_val[3];  end
        c_asr:   begin w_nv = {{4{r_val[31]}}, r_val[31:4]};  w_nc = r_val[3];  end
        default: begin w_nv = {r_val[3:0], r_val[31:4]};      w_nc = r_val[3];  end
      endcase
    end else begin
      case (r_type)
        c_lsl:   begin w_nv = {r_val[30:0], 1'b0};            w_nc = r_val[31]; end
        c_lsr:   begin w_nv = {1'b0, r_val[31:1]};            w_nc = r_val[0];  end
        c_asr:   begin w_nv = {r_val[31], r_val[31:1]};       w_nc = r_val[0];  end
        default: begin w_nv = {r_val[0], r_val[31:1]};        w_nc = r_val[0];  end
      endcase
    end
  end

  assign stall = ((r_state == S_IDLE) && start && !flush) || (r_state == S_SHIFT);

  // result/carry_out are written only on entry to DONE, so an aborted
  // operation leaves the previous result visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_val     <= 32'd0;
      r_cnt     <= 6'd0;
      r_type    <= 2'd0;
      result    <= 32'd0;
      carry_out <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_val  <= val_rm;
            r_type <= shift_type;
            r_cnt  <= w_n;
            busy   <= 1'b1;
            if (w_n == 6'd0) begin
              r_state   <= S_DONE;
              done      <= 1'b1;
              result    <= val_rm;
              carry_out <= w_zero_c;
            end else begin
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_val <= w_nv;
          r_cnt <= w_ncnt;
          if (w_ncnt == 6'd0) begin
            r_state   <= S_DONE;
            done      <= 1'b1;
            result    <= w_nv;
            carry_out <= w_nc;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_shift_seq                                                  |
// | Description : Self-checking bench for shift_seq (honours SHIFT_SEQ_FAST_EN)|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_shift_seq;

  logic        clk = 1'b0;
  logic        rst, start, flush, carry_in;
  logic [1:0]  shift_type;
  logic [31:0] val_rm;
  logic [7:0]  amount;
  logic        stall, busy, done, carry_out;
  logic [31:0] result;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [31:0] prev_r;
  logic        prev_c;

  typedef struct {
    logic [31:0] r;
    logic        c;
    int          lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0]  ty;
    logic [31:0] v;
    logic [7:0]  a;
    logic        cin;
    logic [31:0] er;
    logic        ec;
    int          n;
  } vec_t;
  vec_t tbl[10];

  shift_seq dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .shift_type(shift_type),
    .val_rm(val_rm), .amount(amount), .carry_in(carry_in), .stall(stall),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int steps(input int n);
`ifdef SHIFT_SEQ_FAST_EN
    return n / 4 + n % 4;
`else
    return n;
`endif
  endfunction

  // Closed-form architectural shift, independent of any stepping scheme.
  function automatic void model(input logic [1:0] ty, input logic [31:0] v,
                                input logic [7:0] a, input logic cin,
                                output logic [31:0] r, output logic c, output int n);
    int ai;
    int s;
    ai = int'(a);
    r  = v;
    c  = cin;
    n  = 0;
    case (ty)
      2'b00: begin
        n = (ai > 33) ? 33 : ai;
        if (ai == 0) begin r = v; c = cin; end
        else if (ai < 32) begin r = v << ai; c = v[32-ai]; end
        else if (ai == 32) begin r = 32'd0; c = v[0]; end
        else begin r = 32'd0; c = 1'b0; end
      end
      2'b01: begin
        n = (ai > 33) ? 33 : ai;
        if (ai == 0) begin r = v; c = cin; end
        else if (ai < 32) begin r = v >> ai; c = v[ai-1]; end
        else if (ai == 32) begin r = 32'd0; c = v[31]; end
        else begin r = 32'd0; c = 1'b0; end
      end
      2'b10: begin
        n = (ai > 32) ? 32 : ai;
        if (ai == 0) begin r = v; c = cin; end
        else if (ai < 32) begin r = 32'($signed(v) >>> ai); c = v[ai-1]; end
        else begin r = {32{v[31]}}; c = v[31]; end
      end
      default: begin
        s = ai % 32;
        n = s;
        if (ai == 0) begin r = v; c = cin; end
        else if (s == 0) begin r = v; c = v[31]; end
        else begin r = (v >> s) | (v << (32 - s)); c = r[31]; end
      end
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one operation, push its expectation, then pop and compare at done.
  task automatic run_op(input logic [1:0] ty, input logic [31:0] v, input logic [7:0] a,
                        input logic cin, input logic [31:0] er, input logic ec,
                        input int n, input bit poke);
    exp_t e;
    int   t;
    bit   seen;
    bit   shift_ok;
    e.r = er; e.c = ec; e.lat = 1 + steps(n);
    sb.push_back(e);
    @(negedge clk);
    shift_type = ty; val_rm = v; amount = a; carry_in = cin; start = 1'b1;
    t = cyc;
    #1 chk("stall_issue", 32'(stall), 32'd1);
    @(negedge clk);
    start    = 1'b0;
    seen     = 1'b0;
    shift_ok = 1'b1;
    for (int k = 0; k < 60 && !seen; k++) begin
      if (done) seen = 1'b1;
      else begin
        if (stall !== 1'b1 || busy !== 1'b1) shift_ok = 1'b0;
        if (poke && k == 0) begin
          start = 1'b1; val_rm = 32'hFFFF_FFFF; amount = 8'd1; shift_type = 2'b01;
        end else start = 1'b0;
        @(negedge clk);
      end
    end
    start = 1'b0;
    e = sb.pop_front();
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL done_timeout: no done within 60 cycles (type %0d amount %0d)", ty, a);
    end else begin
      chk("result", result, e.r);
      chk("carry_out", 32'(carry_out), 32'(e.c));
      chk("latency", 32'(cyc - t), 32'(e.lat));
      chk("stall_done", 32'(stall), 32'd0);
      chk("busy_done", 32'(busy), 32'd1);
      chk("stall_shift", 32'(shift_ok), 32'd1);
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
      prev_r = e.r;
      prev_c = e.c;
    end
  endtask

  // LSL by 10 aborted in its third SHIFT cycle by flush or reset.
  task automatic abort_op(input bit use_rst);
    int dones;
    @(negedge clk);
    shift_type = 2'b00; val_rm = 32'h0000_1234; amount = 8'd10; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    if (use_rst) begin prev_r = 32'd0; prev_c = 1'b0; end
    chk(use_rst ? "rst_busy" : "flush_busy", 32'(busy), 32'd0);
    chk(use_rst ? "rst_done" : "flush_done", 32'(done), 32'd0);
    chk(use_rst ? "rst_stall" : "flush_stall", 32'(stall), 32'd0);
    chk(use_rst ? "rst_result" : "flush_result", result, prev_r);
    chk(use_rst ? "rst_carry" : "flush_carry", 32'(carry_out), 32'(prev_c));
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) dones++;
      @(negedge clk);
    end
    chk(use_rst ? "rst_no_done" : "flush_no_done", 32'(dones), 32'd0);
  endtask

  initial begin
    logic [31:0] er;
    logic        ec;
    int          n;
    logic [1:0]  ty;
    logic [31:0] v;
    logic [7:0]  a;
    logic        cin;

    tbl[0] = '{2'b00, 32'h0000_0001, 8'd4,   1'b1, 32'h0000_0010, 1'b0, 4};
    tbl[1] = '{2'b00, 32'h0000_0001, 8'd32,  1'b0, 32'h0000_0000, 1'b1, 32};
    tbl[2] = '{2'b00, 32'h0000_0001, 8'd33,  1'b0, 32'h0000_0000, 1'b0, 33};
    tbl[3] = '{2'b00, 32'h0000_0001, 8'd200, 1'b0, 32'h0000_0000, 1'b0, 33};
    tbl[4] = '{2'b10, 32'h8000_0000, 8'd40,  1'b0, 32'hFFFF_FFFF, 1'b1, 32};
    tbl[5] = '{2'b01, 32'h8000_0001, 8'd1,   1'b0, 32'h4000_0000, 1'b1, 1};
    tbl[6] = '{2'b11, 32'h0000_00F0, 8'd36,  1'b1, 32'h0000_000F, 1'b0, 4};
    tbl[7] = '{2'b11, 32'h8000_0000, 8'd32,  1'b0, 32'h8000_0000, 1'b1, 0};
    tbl[8] = '{2'b10, 32'h1234_5678, 8'd0,   1'b1, 32'h1234_5678, 1'b1, 0};
    tbl[9] = '{2'b11, 32'hDEAD_BEEF, 8'd0,   1'b1, 32'hDEAD_BEEF, 1'b1, 0};

    rst = 1'b1; start = 1'b1; flush = 1'b1; shift_type = 2'b00;
    val_rm = 32'hA5A5_A5A5; amount = 8'd0; carry_in = 1'b1;
    prev_r = 32'd0; prev_c = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0; start = 1'b0; flush = 1'b0;
    #1;
    chk("reset_result", result, 32'd0);
    chk("reset_carry", 32'(carry_out), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);

    foreach (tbl[i])
      run_op(tbl[i].ty, tbl[i].v, tbl[i].a, tbl[i].cin, tbl[i].er, tbl[i].ec, tbl[i].n, 1'b0);

    for (int i = 0; i < 16; i++) begin
      ty  = 2'($urandom_range(0, 3));
      v   = $urandom;
      a   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40));
      cin = 1'($urandom_range(0, 1));
      model(ty, v, a, cin, er, ec, n);
      run_op(ty, v, a, cin, er, ec, n, 1'b0);
    end

    run_op(2'b11, 32'hDEAD_BEEF, 8'd0, 1'b1, 32'hDEAD_BEEF, 1'b1, 0, 1'b0);

    // start during SHIFT must not disturb the running LSL
    run_op(2'b00, 32'h0000_0001, 8'd10, 1'b0, 32'h0000_0400, 1'b0, 10, 1'b1);
    run_op(2'b11, 32'hDEAD_BEEF, 8'd0, 1'b1, 32'hDEAD_BEEF, 1'b1, 0, 1'b0);

    abort_op(1'b0);
    abort_op(1'b1);

    // flush beats a simultaneous start in IDLE
    @(negedge clk);
    start = 1'b1; flush = 1'b1; val_rm = 32'h5555_5555; amount = 8'd0;
    #1 chk("flush_start_stall", 32'(stall), 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", 32'(busy), 32'd0);
    chk("flush_start_done", 32'(done), 32'd0);
    chk("flush_start_result", result, prev_r);

    run_op(2'b01, 32'hF000_0000, 8'd8, 1'b0, 32'h00F0_0000, 1'b0, 8, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
